// File: rtl/noc_params.sv
// Shared NoC types: flit type tag and the flit payload struct.
package noc_params;

    localparam int unsigned FLIT_WIDTH = 32;

    typedef enum logic [1:0] {
        HEAD     = 2'd0,
        BODY     = 2'd1,
        TAIL     = 2'd2,
        HEADTAIL = 2'd3
    } flit_type_t;

    typedef struct packed {
        flit_type_t             flit_type;
        logic [FLIT_WIDTH-1:0]  data;
    } flit_t;

endpackage

// File: rtl/circular_buffer.sv
// Circular flit FIFO: storage, read/write pointers, occupancy count and
// empty/full/overflow indication. Combinational read of the head entry.
module circular_buffer
    import noc_params::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  write_req,
    input  flit_t wr_data,
    input  logic  pop,
    output flit_t rd_data_c,
    output logic  empty_c,
    output logic  full_c,
    output logic  overflow_c
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    flit_t              mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic               push;

    // A pop in the same cycle frees a slot, so a write into a full FIFO is accepted then.
    always_comb begin
        empty_c    = (count == CNT_W'(0));
        full_c     = (count == CNT_W'(DEPTH));
        push       = write_req & (~full_c | pop);
        overflow_c = write_req & full_c & ~pop;
        rd_data_c  = mem[rd_ptr];
    end

    // Payload storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/flit_input_buffer.sv
// Per-input-port flit buffer with credit-based flow control feeding one
// request bit of the switch allocator.
module flit_input_buffer
    import noc_params::*;
#(
    parameter int unsigned BUFFER_SIZE      = 8,
    parameter int unsigned DOWNSTREAM_DEPTH = 8
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  flit_valid_i,
    input  flit_t flit_i,
    output logic  credit_o,
    output logic  request_o,
    input  logic  grant_i,
    output flit_t flit_o,
    output logic  flit_valid_o,
    input  logic  credit_i,
    output logic  empty_o,
    output logic  full_o,
    output logic  error_o
);

    localparam int unsigned CRED_W = $clog2(DOWNSTREAM_DEPTH) + 1;

    logic [CRED_W-1:0] cred_cnt;
    logic              pop;
    logic              overflow;
    logic              cred_full;

    circular_buffer #(
        .DEPTH (BUFFER_SIZE)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .write_req  (flit_valid_i),
        .wr_data    (flit_i),
        .pop        (pop),
        .rd_data_c  (flit_o),
        .empty_c    (empty_o),
        .full_c     (full_o),
        .overflow_c (overflow)
    );

    // Request depends only on registered state, so no loop through the arbiter.
    always_comb begin
        cred_full    = (cred_cnt == CRED_W'(DOWNSTREAM_DEPTH));
        request_o    = ~empty_o & (cred_cnt != CRED_W'(0));
        pop          = request_o & grant_i;
        flit_valid_o = pop;
    end

    // Downstream credit tracking; an unsolicited credit at the ceiling saturates.
    always_ff @(posedge clk) begin
        if (rst) begin
            cred_cnt <= CRED_W'(DOWNSTREAM_DEPTH);
        end else begin
            case ({pop, credit_i})
                2'b10:   cred_cnt <= cred_cnt - CRED_W'(1);
                2'b01:   cred_cnt <= cred_full ? cred_cnt : cred_cnt + CRED_W'(1);
                default: cred_cnt <= cred_cnt;
            endcase
        end
    end

    // Upstream credit return one cycle after each pop, plus sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            credit_o <= 1'b0;
            error_o  <= 1'b0;
        end else begin
            credit_o <= pop;
            if (overflow || (credit_i && !pop && cred_full)) begin
                error_o <= 1'b1;
            end
        end
    end

endmodule

// File: doc/flit_input_buffer.md
Name: flit_input_buffer

Overview:
Per-input-port flit FIFO with credit-based flow control, directly upstream of round_robin_arbiter in the switch-allocation stage. It stores incoming flits and raises a request bit into one arbiter requests_i slot when it holds a flit and the downstream buffer has a free slot. On grant it pops the head flit toward the crossbar, returns one credit upstream, and debits its downstream credit counter.

Parameters:
BUFFER_SIZE, 8, FIFO depth in flits; power of two, >= 2.
FLIT_WIDTH, 32, payload bits per flit, excluding type field.
DOWNSTREAM_DEPTH, 8, credits available at reset; equals the downstream buffer depth.

Ports:
clk  input  1  clock; all state changes on rising edge.
rst  input  1  synchronous, active-high reset.
flit_valid_i  input  1  upstream write strobe.
flit_i  input  flit_t  incoming flit: type field plus FLIT_WIDTH payload.
credit_o  output  1  one-cycle pulse per popped flit, returned upstream.
request_o  output  1  to one bit of the arbiter requests_i.
grant_i  input  1  from the matching bit of the arbiter grants_o.
flit_o  output  flit_t  head-of-FIFO flit, valid while request_o is high.
flit_valid_o  output  1  high in the cycle a granted flit leaves (request_o & grant_i).
credit_i  input  1  credit returned by the downstream buffer.
empty_o  output  1  FIFO empty.
full_o  output  1  FIFO full.
error_o  output  1  sticky protocol-error flag.

Behaviour:
- Reset is synchronous, active-high, and overrides every other input in that cycle. After reset:
  - read pointer, write pointer and count = 0
  - empty_o = 1, full_o = 0, request_o = 0, credit_o = 0, error_o = 0
  - credit counter = DOWNSTREAM_DEPTH
  - flit_o is don't-care
- Reset asserted mid-packet discards all stored flits; no credits are emitted for them.
- Storage is a circular buffer. Pointers have width $clog2(BUFFER_SIZE) and wrap from BUFFER_SIZE-1 to 0. A separate count of width $clog2(BUFFER_SIZE)+1 holds 0..BUFFER_SIZE.
- push = flit_valid_i & (!full_o | pop).
- pop = request_o & grant_i.
- grant_i while request_o = 0 is ignored: no pop, no state change.
- push and pop in the same cycle leave count unchanged. This applies when full, so a write into a full FIFO that is popping the same cycle is accepted.
- flit_valid_i while full_o = 1 with no pop: write dropped, error_o set.
- Write-to-request latency is one cycle. A flit written into an empty FIFO raises request_o on the next cycle; there is no bypass path.
- request_o = !empty_o & (credit counter != 0). It is combinational from registered state and independent of grant_i, so there is no combinational loop with the arbiter.
- flit_o = storage[read pointer], combinational read.
- Pop advances the read pointer. credit_o is registered and pulses exactly one cycle after each pop.
- Credit counter, width $clog2(DOWNSTREAM_DEPTH)+1:
  - pop alone decrements it.
  - credit_i alone increments it.
  - pop and credit_i together leave it unchanged.
  - credit_i with counter = DOWNSTREAM_DEPTH and no pop saturates the counter and sets error_o.
- error_o is sticky until reset.
- The block imposes no packet-level locking; wormhole/VC ownership is handled elsewhere.

Decomposition:
- noc_params package holds:
  - flit_type_t enum {HEAD, BODY, TAIL, HEADTAIL}
  - flit_t packed struct {flit_type_t flit_type; logic [FLIT_WIDTH-1:0] data}
  - FLIT_WIDTH default
- One natural sub-module: circular_buffer (storage, pointers, count, empty/full, overflow detect).
- flit_input_buffer wraps circular_buffer with the credit counter and request/credit logic.

Test Plan:
- Reset, then write HEAD, BODY, TAIL on consecutive cycles, grant_i held high -> request_o rises one cycle after the first write; flits leave in order on 3 consecutive cycles; credit_o pulses 3 times, each one cycle after its pop; empty_o = 1 at end.
- Write 8 flits, no grant, then a 9th write -> full_o = 1 after the 8th; the 9th is dropped, error_o = 1, count stays 8.
- Full FIFO with grant and write in the same cycle -> write accepted, count stays 8, error_o stays 0.
- DOWNSTREAM_DEPTH = 2, 4 flits queued, grant always high, no credit_i -> exactly 2 pops, then request_o = 0 with empty_o = 0. One credit_i pulse -> exactly 1 more pop.
- Pop and credit_i in the same cycle -> credit counter unchanged. credit_i at counter = 8 -> counter stays 8, error_o = 1.
- Write 5 flits, pop 5, repeat 3 times (pointer wrap) -> output order matches input. Assert rst with 3 flits stored -> next cycle empty_o = 1, request_o = 0, credit counter = DOWNSTREAM_DEPTH, no credit_o pulse.
